// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 multi-cycle sequencer: opcodes, status codes, FSM states.
package y86_pkg;

  localparam logic [3:0] IcodeNop    = 4'h0;
  localparam logic [3:0] IcodeHalt   = 4'h1;
  localparam logic [3:0] IcodeRrmovl = 4'h2;
  localparam logic [3:0] IcodeIrmovl = 4'h3;
  localparam logic [3:0] IcodeRmmovl = 4'h4;
  localparam logic [3:0] IcodeMrmovl = 4'h5;
  localparam logic [3:0] IcodeOpl    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushl  = 4'hA;
  localparam logic [3:0] IcodePopl   = 4'hB;

  // Highest defined opcode; anything above is an illegal instruction.
  localparam logic [3:0] IcodeMax    = IcodePopl;

  typedef enum logic [1:0] {
    StatAok = 2'b00,
    StatHlt = 2'b01,
    StatAdr = 2'b10,
    StatIns = 2'b11
  } stat_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcupd,
    StStop
  } state_e;

  // Opcodes that touch data memory and therefore pass through the MEMORY state.
  function automatic logic needs_mem(logic [3:0] icode);
    return icode inside {IcodeRmmovl, IcodeMrmovl, IcodeCall, IcodeRet, IcodePushl, IcodePopl};
  endfunction

endpackage

// File: rtl/y86_wait_timer.sv
// Loadable down-counter that flags a memory handshake waiting TIMEOUT cycles without an ack.
module y86_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Loading TIMEOUT-1 makes the count hit zero on the TIMEOUT-th waiting cycle.
  localparam logic [W-1:0] LoadVal = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic Enable = (TIMEOUT != 0);

  logic [W-1:0] r_cnt;

  // Reload while not waiting, count down on each cycle without an acknowledge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= LoadVal;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = Enable && !i_load && (r_cnt == '0);

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle Y86 sequencer: steps one instruction through the stages, owns the memory
// handshakes, the PC write strobe, the architectural status and the retired count.
module y86_seq_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  input  logic             imem_err_i,
  input  logic [3:0]       icode_i,
  output logic             dmem_req_o,
  input  logic             dmem_ack_i,
  input  logic             dmem_err_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             execute_en_o,
  output logic             memory_en_o,
  output logic             wb_en_o,
  output logic             pc_we_o,
  output logic [1:0]       stat_o,
  output logic             halted_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  import y86_pkg::*;

  state_e           r_state;
  stat_e            r_stat;
  logic [3:0]       r_icode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_imem_req;
  logic             r_dmem_req;
  logic             r_decode_en;
  logic             r_execute_en;
  logic             r_wb_en;
  logic             r_pc_we;

  logic w_in_wait;
  logic w_wait_ack;
  logic w_timer_load;
  logic w_timer_dec;
  logic w_expire;

  assign w_in_wait    = (r_state == StFetch) || (r_state == StMemory);
  assign w_wait_ack   = (r_state == StFetch) ? imem_ack_i : dmem_ack_i;
  // Holding the timer in load outside FETCH/MEMORY clears it on every entry.
  assign w_timer_load = !w_in_wait;
  assign w_timer_dec  = w_in_wait && !w_wait_ack;

  y86_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_load   (w_timer_load),
    .i_dec    (w_timer_dec),
    .o_expire (w_expire)
  );

  // Stage sequencing, fault capture and registered strobes; an ack always beats the timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_stat       <= StatAok;
      r_icode      <= IcodeNop;
      r_cnt        <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_decode_en  <= 1'b0;
      r_execute_en <= 1'b0;
      r_wb_en      <= 1'b0;
      r_pc_we      <= 1'b0;
    end else begin
      r_decode_en  <= 1'b0;
      r_execute_en <= 1'b0;
      r_wb_en      <= 1'b0;
      r_pc_we      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (run_i) begin
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_ack_i) begin
            r_imem_req <= 1'b0;
            if (imem_err_i) begin
              r_stat  <= StatAdr;
              r_state <= StStop;
            end else if (icode_i > IcodeMax) begin
              r_stat  <= StatIns;
              r_state <= StStop;
            end else if (icode_i == IcodeHalt) begin
              // HALT retires but never updates the PC.
              r_stat  <= StatHlt;
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= StStop;
            end else begin
              r_icode     <= icode_i;
              r_state     <= StDecode;
              r_decode_en <= 1'b1;
            end
          end else if (w_expire) begin
            r_imem_req <= 1'b0;
            r_stat     <= StatAdr;
            r_state    <= StStop;
          end
        end
        StDecode: begin
          r_state      <= StExecute;
          r_execute_en <= 1'b1;
        end
        StExecute: begin
          if (needs_mem(r_icode)) begin
            r_state    <= StMemory;
            r_dmem_req <= 1'b1;
          end else begin
            r_state <= StWriteback;
            r_wb_en <= 1'b1;
          end
        end
        StMemory: begin
          if (dmem_ack_i) begin
            r_dmem_req <= 1'b0;
            if (dmem_err_i) begin
              r_stat  <= StatAdr;
              r_state <= StStop;
            end else begin
              r_state <= StWriteback;
              r_wb_en <= 1'b1;
            end
          end else if (w_expire) begin
            r_dmem_req <= 1'b0;
            r_stat     <= StatAdr;
            r_state    <= StStop;
          end
        end
        StWriteback: begin
          r_state <= StPcupd;
          r_pc_we <= 1'b1;
        end
        StPcupd: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (run_i) begin
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
        StStop: begin
          r_state <= StStop;
        end
      endcase
    end
  end

  // Capture strobes for FETCH/MEMORY follow the acknowledge combinationally.
  assign fetch_en_o   = (r_state == StFetch) && imem_ack_i && !imem_err_i &&
                        (icode_i <= IcodeMax);
  assign memory_en_o  = (r_state == StMemory) && dmem_ack_i && !dmem_err_i;

  assign imem_req_o   = r_imem_req;
  assign dmem_req_o   = r_dmem_req;
  assign decode_en_o  = r_decode_en;
  assign execute_en_o = r_execute_en;
  assign wb_en_o      = r_wb_en;
  assign pc_we_o      = r_pc_we;
  assign stat_o       = r_stat;
  assign halted_o     = (r_stat != StatAok);
  assign busy_o       = (r_state != StIdle) && (r_state != StStop);
  assign instr_cnt_o  = r_cnt;

endmodule

// File: doc/y86_seq_ctrl.md
# y86_seq_ctrl

Multi-cycle sequencer for the Y86 core. It drives a single instruction through fetch, decode, execute, memory, writeback and PC update, one stage per state. It owns the instruction- and data-memory request/acknowledge handshakes and generates the PC write strobe consumed by `pc_update`. It also produces the architectural status code, so faulting or halted instructions never advance the PC.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles a memory request may wait for an acknowledge; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `run_i` in 1: level; permits starting or continuing execution.
- `imem_req_o` out 1: instruction fetch request (level).
- `imem_ack_i` in 1: fetch complete; `icode_i`/`imem_err_i` valid this cycle.
- `imem_err_i` in 1: fetch address error.
- `icode_i` in 4: opcode from the fetch stage.
- `dmem_req_o` out 1: data memory request (level).
- `dmem_ack_i` in 1: data access complete.
- `dmem_err_i` in 1: data address error.
- `fetch_en_o`, `decode_en_o`, `execute_en_o`, `memory_en_o`, `wb_en_o` out 1 each: one-cycle stage capture strobes.
- `pc_we_o` out 1: one-cycle PC update strobe.
- `stat_o` out 2: AOK=00, HLT=01, ADR=10, INS=11.
- `halted_o` out 1: machine stopped (`stat_o` ≠ AOK).
- `busy_o` out 1: FSM not in IDLE or STOP.
- `instr_cnt_o` out CNT_W: retired instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- **IDLE**
  - All strobes are 0.
  - If `run_i`=1, go to FETCH.
- **FETCH**
  - `imem_req_o`=1.
  - On `imem_ack_i`:
    - `imem_err_i`=1: stat←ADR, go to STOP.
    - else, `icode_i` > 4'hB: stat←INS, go to STOP.
    - else, `icode_i`=HALT (4'h1): `fetch_en_o`=1, stat←HLT, count+1, go to STOP.
    - otherwise: `fetch_en_o`=1, latch icode, go to DECODE.
- **DECODE**: `decode_en_o`=1, go to EXECUTE.
- **EXECUTE**
  - `execute_en_o`=1.
  - Latched icode ∈ {RMMOVL 4, MRMOVL 5, CALL 8, RET 9, PUSHL A, POPL B}: go to MEMORY.
  - Otherwise: go to WRITEBACK.
- **MEMORY**
  - `dmem_req_o`=1.
  - On `dmem_ack_i` with `dmem_err_i`=1: stat←ADR, go to STOP.
  - On `dmem_ack_i` otherwise: `memory_en_o`=1, go to WRITEBACK.
- **WRITEBACK**: `wb_en_o`=1, go to PCUPD.
- **PCUPD**
  - `pc_we_o`=1, `instr_cnt_o`+1.
  - Next state: `run_i` ? FETCH : IDLE.
- **Timeout**
  - A wait counter clears on entering FETCH or MEMORY and increments each cycle without an acknowledge.
  - When it reaches `TIMEOUT` (nonzero): stat←ADR, go to STOP.
  - An acknowledge in the same cycle as the timeout wins.
- **STOP**
  - Absorbing; all strobes are 0 and `pc_we_o` is never asserted.
  - Left only by reset.
- `run_i` is sampled only in IDLE and PCUPD; deasserting it mid-instruction completes that instruction.
- `instr_cnt_o` wraps modulo 2^CNT_W.

## Timing
- Reset values: state IDLE; every output 0; `stat_o`=AOK; counter 0.
- An asynchronous reset mid-instruction aborts it. No `pc_we_o` is issued and the latched icode is discarded.
- All outputs are Moore-registered or decoded from state, except `fetch_en_o`/`memory_en_o`. Those two equal state & ack & ~err, combinationally.
- Latency with zero-wait memory:
  - Non-memory instruction: 5 cycles, FETCH through PCUPD.
  - Memory instruction: 6 cycles.
  - Each wait cycle adds 1.
- `stat_o`/`halted_o` update the cycle after the faulting acknowledge and hold until reset.
- Request signals drop the cycle after the acknowledge. A requester must not see an acknowledge without a request.

## Structure
- Shared package `y86_pkg`:
  - icode constants (NOP…POPL)
  - status codes (AOK/HLT/ADR/INS)
  - state enum
  - a function `needs_mem(icode)`
- One sub-module `y86_wait_timer`: a loadable down-counter implementing the TIMEOUT check, instantiated once and shared by FETCH and MEMORY.

## Test plan
- Reset, `run_i`=1, icode 0 (NOP) with ack on the first request cycle → `pc_we_o` pulses every 5 cycles; `instr_cnt_o`=3 after 15 cycles.
- icode 5 (MRMOVL), dmem ack after 2 wait cycles → `memory_en_o` 1 cycle; `pc_we_o` 8 cycles after entering FETCH.
- icode 1 (HALT) → `stat_o`=01, `halted_o`=1, no `pc_we_o`, count+1, stuck until `rst_i`.
- icode 4'hC → `stat_o`=11, no `fetch_en_o`, no `pc_we_o`; `imem_err_i` on ack → `stat_o`=10.
- `TIMEOUT`=4, dmem never acks → `stat_o`=10 four cycles after entering MEMORY; ack on exactly the 4th cycle → normal completion.
- `rst_i` asserted during MEMORY → all outputs 0 immediately. `run_i` dropped during EXECUTE → instruction completes, then IDLE with `busy_o`=0.
